// File: rtl/orrs_32bit_core.sv
// orrs_32bit_core: registered bitwise-OR unit with valid/ready handshake and result flags
module orrs_32bit_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic             ones_flag
);
    logic [WIDTH-1:0] r;
    logic             acc;
    assign r        = a | b;
    assign in_ready = !out_valid || out_ready;
    assign acc      = in_valid && in_ready;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y         <= '0;
            out_valid <= 1'b0;
            zero_flag <= 1'b0;
            neg_flag  <= 1'b0;
            ones_flag <= 1'b0;
        end else if (acc) begin
            y         <= r;
            out_valid <= 1'b1;
            zero_flag <= ~|r;
            neg_flag  <= r[WIDTH-1];
            ones_flag <= &r;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_orrs_32bit_core.sv
// tb_orrs_32bit_core: scoreboard bench for the registered OR unit
module tb_orrs_32bit_core;
    localparam int W = 32;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a, b, y;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic         zero_flag, neg_flag, ones_flag;
    logic [W+2:0] q[$];
    logic [W+2:0] last = '0;
    logic         mv = 1'b0;
    logic         armed = 1'b0;
    int           checks = 0;
    int           passes = 0;

    orrs_32bit_core #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .zero_flag(zero_flag), .neg_flag(neg_flag), .ones_flag(ones_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [W+2:0] expect_of(logic [W-1:0] x, logic [W-1:0] z);
        logic [W-1:0] o;
        o = x | z;
        return {o, o == '0, o[W-1], o == '1};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // reference model of the handshake, updated on the same edge as the DUT
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            mv    <= 1'b0;
            last  <= '0;
            armed <= 1'b1;
        end else begin
            if (mv && out_ready) void'(q.pop_front());
            if (in_valid && (!mv || out_ready)) begin
                q.push_back(expect_of(a, b));
                last <= expect_of(a, b);
                mv   <= 1'b1;
            end else if (out_ready) begin
                mv <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("out_valid", 64'(out_valid), 64'(mv));
            check("y_flags", 64'({y, zero_flag, neg_flag, ones_flag}), 64'(last));
            if (rst_n) check("in_ready", 64'(in_ready), 64'(!mv || out_ready));
            if (out_valid && out_ready && rst_n) begin
                if (q.size() == 0) check("sb_empty", 64'(1), 64'(0));
                else check("sb_result", 64'({y, zero_flag, neg_flag, ones_flag}), 64'(q[0]));
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] z, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        a         = x;
        b         = z;
        out_ready = r;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; a = '1; b = '1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; in_valid = 1'b0;
        drive(1, 32'h00000000, 32'h00000000, 1);
        drive(1, 32'h00000000, 32'hFFFFFFFF, 1);
        drive(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        drive(1, 32'hA5A5A5A5, 32'h5A5A5A5A, 1);
        drive(1, 32'hFF00FF00, 32'h00FF00FF, 1);
        drive(1, 32'h12340000, 32'h00005678, 1);
        drive(0, 32'hDEADBEEF, 32'h0, 1);
        drive(0, 32'h0, 32'h0, 1);
        drive(1, 32'h11111111, 32'h22222222, 1);
        repeat (3) drive(1, 32'hAAAA0000, 32'h0000BBBB, 0);
        drive(1, 32'hAAAA0000, 32'h0000BBBB, 1);
        drive(0, 32'h0, 32'h0, 1);
        drive(0, 32'h0, 32'h0, 1);
        drive(1, 32'h80000000, 32'h0, 0);
        drive(0, 32'h0, 32'h0, 0);
        @(posedge clk);
        #1 rst_n = 1'b0; in_valid = 1'b1; a = 32'h5; out_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1; in_valid = 1'b0;
        drive(0, 32'h0, 32'h0, 1);
        drive(0, 32'h0, 32'h0, 1);
        @(negedge clk);
        check("drain", 64'(q.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
